// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode, replacing the IF/ID register.
// Define INST_QUEUE_BYPASS_EN to let enqueued lanes fill empty output lanes in the same cycle.
module inst_queue #(
  parameter int DEPTH  = 8,
  parameter int IN_W   = 2,
  parameter int OUT_W  = 2,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [IN_W-1:0]            in_valid,
  input  logic [IN_W*PC_W-1:0]       in_pc,
  input  logic [IN_W*PC_W-1:0]       in_npc,
  input  logic [IN_W*INST_W-1:0]     in_inst,
  output logic                       in_ready,
  output logic [OUT_W-1:0]           out_valid,
  output logic [OUT_W*PC_W-1:0]      out_pc,
  output logic [OUT_W*PC_W-1:0]      out_npc,
  output logic [OUT_W*INST_W-1:0]    out_inst,
  input  logic [OUT_W-1:0]           out_take,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic [PC_W-1:0]   mem_npc  [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] n_enq, n_deq, n_byp;
  logic             enq_run, deq_run;

  logic              wr_en   [IN_W];
  logic [PTR_W-1:0]  wr_addr [IN_W];
  logic [PC_W-1:0]   wr_pc   [IN_W];
  logic [PC_W-1:0]   wr_npc  [IN_W];
  logic [INST_W-1:0] wr_inst [IN_W];

  assign in_ready = (count <= CNT_W'(DEPTH - IN_W));
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

  always_comb begin
    n_enq   = '0;
    enq_run = in_ready;
    for (int unsigned k = 0; k < IN_W; k++) begin
      if (enq_run && in_valid[k]) n_enq = n_enq + CNT_W'(1);
      else                        enq_run = 1'b0;
    end
  end

  // Read side: registered entries, optionally overlaid by same-cycle input lanes.
  always_comb begin
    logic [CNT_W-1:0] byp_k;
    byp_k = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      out_valid[i]                 = (count > CNT_W'(i));
      out_pc[i*PC_W +: PC_W]       = mem_pc[head + PTR_W'(i)];
      out_npc[i*PC_W +: PC_W]      = mem_npc[head + PTR_W'(i)];
      out_inst[i*INST_W +: INST_W] = mem_inst[head + PTR_W'(i)];
`ifdef INST_QUEUE_BYPASS_EN
      if (!flush && !rst && (CNT_W'(i) >= count)) begin
        byp_k = CNT_W'(i) - count;
        if (byp_k < n_enq) begin
          out_valid[i]                 = 1'b1;
          out_pc[i*PC_W +: PC_W]       = in_pc[int'(byp_k)*PC_W +: PC_W];
          out_npc[i*PC_W +: PC_W]      = in_npc[int'(byp_k)*PC_W +: PC_W];
          out_inst[i*INST_W +: INST_W] = in_inst[int'(byp_k)*INST_W +: INST_W];
        end
      end
`endif
    end
  end

  always_comb begin
    n_deq   = '0;
    deq_run = 1'b1;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      if (deq_run && out_take[i] && out_valid[i]) n_deq = n_deq + CNT_W'(1);
      else                                        deq_run = 1'b0;
    end
  end

`ifdef INST_QUEUE_BYPASS_EN
  // Takes beyond the stored entries consume bypassed input lanes, which are never written.
  assign n_byp = (n_deq > count) ? (n_deq - count) : '0;
`else
  assign n_byp = '0;
`endif

  always_comb begin
    int unsigned src;
    for (int unsigned k = 0; k < IN_W; k++) begin
      src        = k + int'(n_byp);
      wr_en[k]   = !rst && !flush && (CNT_W'(src) < n_enq);
      wr_addr[k] = tail + PTR_W'(k);
      wr_pc[k]   = '0;
      wr_npc[k]  = '0;
      wr_inst[k] = '0;
      if (src < IN_W) begin
        wr_pc[k]   = in_pc[src*PC_W +: PC_W];
        wr_npc[k]  = in_npc[src*PC_W +: PC_W];
        wr_inst[k] = in_inst[src*INST_W +: INST_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < IN_W; k++) begin
      if (wr_en[k]) begin
        mem_pc[wr_addr[k]]   <= wr_pc[k];
        mem_npc[wr_addr[k]]  <= wr_npc[k];
        mem_inst[wr_addr[k]] <= wr_inst[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_deq - n_byp);
      tail  <= tail + PTR_W'(n_enq - n_byp);
      count <= count + n_enq - n_deq;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed-vector bench for inst_queue (DEPTH=4, IN_W=2, OUT_W=2).
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [1:0]  in_valid, out_take, out_valid;
  logic [63:0] in_pc, in_npc, in_inst;
  logic [63:0] out_pc, out_npc, out_inst;
  logic        in_ready, full, empty;
  logic [2:0]  count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(4), .IN_W(2), .OUT_W(2), .PC_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_npc(in_npc), .in_inst(in_inst),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_npc(out_npc), .out_inst(out_inst),
    .out_take(out_take),
    .count(count), .full(full), .empty(empty)
  );

  typedef struct {
    logic        rst, flush;
    logic [1:0]  vld;
    logic [31:0] pc0, pc1;
    logic [1:0]  take;
    logic [2:0]  cnt;
    logic [1:0]  ov;
    logic        rdy, fl, em;
    logic [31:0] epc0, epc1;
  } vec_t;

  vec_t vec [20];

  function automatic logic [31:0] inst_of(input logic [31:0] p);
    return {p[15:0], ~p[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic f, input logic [1:0] v,
                       input logic [31:0] p0, input logic [31:0] p1, input logic [1:0] t);
    rst      = r;
    flush    = f;
    in_valid = v;
    in_pc    = {p1, p0};
    in_npc   = {p1 + 32'd4, p0 + 32'd4};
    in_inst  = {inst_of(p1), inst_of(p0)};
    out_take = t;
  endtask

  task automatic check_lane(input string tag, input int lane, input logic [31:0] pc);
    logic [31:0] apc, anpc, ainst;
    apc   = out_pc[lane*32 +: 32];
    anpc  = out_npc[lane*32 +: 32];
    ainst = out_inst[lane*32 +: 32];
    check({tag, "_pc"},   64'(apc),   64'(pc));
    check({tag, "_npc"},  64'(anpc),  64'(pc + 32'd4));
    check({tag, "_inst"}, 64'(ainst), 64'(inst_of(pc)));
  endtask

  initial begin
    //          rst   flush vld    pc0        pc1        take   cnt   ov     rdy   fl    em    epc0       epc1
    vec[0]  = '{1'b1, 1'b0, 2'b00, 32'h0,     32'h0,     2'b00, 3'd0, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0,     32'h0};
    vec[1]  = '{1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b00, 3'd0, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0,     32'h0};
    vec[2]  = '{1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b11, 3'd0, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0,     32'h0};
    vec[3]  = '{1'b0, 1'b0, 2'b11, 32'h100,   32'h104,   2'b00, 3'd2, 2'b11, 1'b1, 1'b0, 1'b0, 32'h100,   32'h104};
    vec[4]  = '{1'b0, 1'b0, 2'b11, 32'h108,   32'h10C,   2'b00, 3'd4, 2'b11, 1'b0, 1'b1, 1'b0, 32'h100,   32'h104};
    vec[5]  = '{1'b0, 1'b0, 2'b11, 32'h180,   32'h184,   2'b00, 3'd4, 2'b11, 1'b0, 1'b1, 1'b0, 32'h100,   32'h104};
    vec[6]  = '{1'b0, 1'b0, 2'b11, 32'h110,   32'h114,   2'b11, 3'd2, 2'b11, 1'b1, 1'b0, 1'b0, 32'h108,   32'h10C};
    vec[7]  = '{1'b0, 1'b0, 2'b11, 32'h110,   32'h114,   2'b00, 3'd4, 2'b11, 1'b0, 1'b1, 1'b0, 32'h108,   32'h10C};
    vec[8]  = '{1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b11, 3'd2, 2'b11, 1'b1, 1'b0, 1'b0, 32'h110,   32'h114};
    vec[9]  = '{1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b10, 3'd2, 2'b11, 1'b1, 1'b0, 1'b0, 32'h110,   32'h114};
    vec[10] = '{1'b0, 1'b0, 2'b01, 32'h118,   32'h1F0,   2'b01, 3'd2, 2'b11, 1'b1, 1'b0, 1'b0, 32'h114,   32'h118};
    vec[11] = '{1'b0, 1'b0, 2'b10, 32'h1F4,   32'h1F8,   2'b00, 3'd2, 2'b11, 1'b1, 1'b0, 1'b0, 32'h114,   32'h118};
    vec[12] = '{1'b0, 1'b0, 2'b11, 32'h11C,   32'h120,   2'b01, 3'd3, 2'b11, 1'b0, 1'b0, 1'b0, 32'h118,   32'h11C};
    vec[13] = '{1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b11, 3'd1, 2'b01, 1'b1, 1'b0, 1'b0, 32'h120,   32'h0};
    vec[14] = '{1'b0, 1'b0, 2'b11, 32'h124,   32'h128,   2'b00, 3'd3, 2'b11, 1'b0, 1'b0, 1'b0, 32'h120,   32'h124};
    vec[15] = '{1'b0, 1'b1, 2'b11, 32'h12C,   32'h130,   2'b01, 3'd0, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0,     32'h0};
    vec[16] = '{1'b0, 1'b0, 2'b11, 32'h300,   32'h304,   2'b00, 3'd2, 2'b11, 1'b1, 1'b0, 1'b0, 32'h300,   32'h304};
    vec[17] = '{1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b01, 3'd1, 2'b01, 1'b1, 1'b0, 1'b0, 32'h304,   32'h0};
    vec[18] = '{1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b01, 3'd0, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0,     32'h0};
    vec[19] = '{1'b1, 1'b0, 2'b11, 32'h400,   32'h404,   2'b00, 3'd0, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0,     32'h0};

    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    @(posedge clk);
    #1;

    // Inputs are returned to idle before sampling so any bypass path cannot affect the check.
    for (int i = 0; i < 20; i++) begin
      drive(vec[i].rst, vec[i].flush, vec[i].vld, vec[i].pc0, vec[i].pc1, vec[i].take);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
      #1;
      check($sformatf("v%0d_count", i),     64'(count),     64'(vec[i].cnt));
      check($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vec[i].ov));
      check($sformatf("v%0d_in_ready", i),  64'(in_ready),  64'(vec[i].rdy));
      check($sformatf("v%0d_full", i),      64'(full),      64'(vec[i].fl));
      check($sformatf("v%0d_empty", i),     64'(empty),     64'(vec[i].em));
      if (vec[i].ov[0]) check_lane($sformatf("v%0d_l0", i), 0, vec[i].epc0);
      if (vec[i].ov[1]) check_lane($sformatf("v%0d_l1", i), 1, vec[i].epc1);
    end

    // Same-cycle view of an enqueue into an empty queue.
    drive(1'b0, 1'b0, 2'b11, 32'h200, 32'h204, 2'b01);
    #2;
`ifdef INST_QUEUE_BYPASS_EN
    check("byp_same_valid", 64'(out_valid), 64'(2'b11));
    check_lane("byp_same_l0", 0, 32'h200);
    check_lane("byp_same_l1", 1, 32'h204);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    #1;
    check("byp_next_count", 64'(count), 64'(3'd1));
    check("byp_next_valid", 64'(out_valid), 64'(2'b01));
    check_lane("byp_next_l0", 0, 32'h204);
`else
    check("nobyp_same_valid", 64'(out_valid), 64'(2'b00));
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    #1;
    check("nobyp_next_count", 64'(count), 64'(3'd2));
    check("nobyp_next_valid", 64'(out_valid), 64'(2'b11));
    check_lane("nobyp_next_l0", 0, 32'h200);
    check_lane("nobyp_next_l1", 1, 32'h204);
`endif

    // Flush while full with a same-cycle enqueue, then enqueue right after.
    drive(1'b0, 1'b0, 2'b11, 32'h500, 32'h504, 2'b00);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 2'b11, 32'h508, 32'h50C, 2'b11);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 2'b11, 32'h600, 32'h604, 2'b00);
    #1;
    check("flush_empty", 64'(empty), 64'(1'b1));
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    #1;
    check("post_flush_count", 64'(count), 64'(3'd2));
    check_lane("post_flush_l0", 0, 32'h600);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/inst_queue.md
# inst_queue

Parametrised circular instruction queue between the fetch stage and the decode/issue stage; it replaces the IF/ID pipeline register. Each cycle it accepts up to `IN_W` fetched instructions (pc, predicted npc, instruction word) and presents the oldest `OUT_W` entries to decode. Decode consumes them with a per-lane take mask. The queue tracks occupancy with explicit valid state and head/tail pointers rather than null-entry compares, and is flushed on branch mispredict.

## Interface
Parameters:
- `DEPTH`, 8, entry count; power of two, ≥ `IN_W` and ≥ `OUT_W`.
- `IN_W`, 2, enqueue lanes.
- `OUT_W`, 2, dequeue lanes.
- `PC_W`, 32, pc/npc width.
- `INST_W`, 32, instruction width.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  mispredict/redirect; discards all entries.
- `in_valid`  in  `IN_W`  lane valid; lane 0 is the oldest instruction.
- `in_pc`, `in_npc`  in  `IN_W*PC_W`  packed; lane i occupies bits [i*PC_W +: PC_W].
- `in_inst`  in  `IN_W*INST_W`  packed, same lane order.
- `in_ready`  out  1  queue can accept a full `IN_W` group this cycle.
- `out_valid`  out  `OUT_W`  lane i holds the (i+1)-th oldest entry.
- `out_pc`, `out_npc`  out  `OUT_W*PC_W`  packed.
- `out_inst`  out  `OUT_W*INST_W`  packed.
- `out_take`  in  `OUT_W`  decode consumes lane i this cycle.
- `count`  out  `$clog2(DEPTH+1)`  current occupancy.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.

## Operation
- State: the `DEPTH` × (`PC_W`+`PC_W`+`INST_W`) array, `head`/`tail` pointers (`$clog2(DEPTH)` bits, wrap modulo `DEPTH`), and `count`.
- Effective enqueue: lane i is enqueued iff `in_ready` and `in_valid[0..i]` are all 1. Lanes above the first 0 are ignored, with no holes. `n_enq` is the length of that prefix. Entries are written at `tail+k` for k < `n_enq`, and `tail` advances by `n_enq`.
- `in_ready = (DEPTH - count) >= IN_W`. It is computed from registered `count` only; a same-cycle dequeue does not raise it. Enqueue is all-or-nothing: when `in_ready`=0 nothing is written, and fetch holds its group.
- Output lane i = entry at `head+i`. `out_valid[i] = (count > i)`. Data on invalid lanes is don't-care.
- Effective dequeue: `n_deq` is the length of the longest prefix where `out_take[i] & out_valid[i]`. `head` advances by `n_deq`. A take on a lane above a 0, or on an invalid lane, is ignored.
- `count_next = count + n_enq - n_deq`. This holds for simultaneous enqueue and dequeue, including when `count` is 0 or `DEPTH`.
- Priority: `rst` > `flush` > normal operation. `rst` or `flush` sets `head`, `tail` and `count` to 0 and discards same-cycle enqueue and dequeue. Array contents are not cleared.

## Timing
- Reset values: `out_valid`=0, `count`=0, `empty`=1, `full`=0, `in_ready`=1. `out_*` data outputs are don't-care.
- Enqueue-to-output latency is 1 cycle: a group written at edge N appears on `out_*` after edge N.
- `out_*`, `count`, `full`, `empty` and `in_ready` are functions of registers only. `out_take` affects state only at the next edge, with no combinational path to outputs. Exception: the bypass feature below.
- Flush at edge N: outputs show an empty queue after N. An enqueue presented in cycle N+1 is accepted normally.
- Pointer wrap (e.g. `tail`=7, `n_enq`=2, `DEPTH`=8) writes entries 7 and 0.

## Configuration
- `INST_QUEUE_BYPASS_EN` defined: when `count` < `OUT_W`, input lanes fill the empty output lanes combinationally in the same cycle. Output lane `count+k` shows input lane k when that lane is effectively enqueued. Bypassed lanes that are taken in the same cycle are not written, and `tail` advances only by the lanes not consumed. `flush`=1 suppresses the bypass.
- Not defined: no input-to-output combinational path; latency is always 1 cycle.

## Test plan
All scenarios use DEPTH=4, IN_W=2, OUT_W=2.
- Reset then idle: `count`=0, `empty`=1, `in_ready`=1, `out_valid`=00 for all cycles.
- Enqueue pc 0x100/0x104, then 0x108/0x10C, with no take: `count` 2→4, `full`=1, `in_ready`=0. A third group is dropped and `count` stays 4.
- With 4 entries, assert `out_take`=11 and enqueue 0x110/0x114 in the same cycle: `in_ready`=0, so `count`=2 and the outputs show 0x108/0x10C. Next cycle the enqueue is accepted, `count`=4, and the wrap order is 0x108, 0x10C, 0x110, 0x114.
- `out_take`=10 (lane 1 only) with `count`=2: `n_deq`=0, and the queue is unchanged.
- `flush` with `count`=3 while enqueueing 2 lanes and taking 1: next cycle `count`=0, `out_valid`=00, `empty`=1.
- `INST_QUEUE_BYPASS_EN`: start empty, present `in_valid`=11 (pc 0x200/0x204) with `out_take`=01. Same cycle, `out_pc` lane 0 = 0x200. Next cycle `count`=1 and `out_pc` lane 0 = 0x204.
